// File: rtl/usb_fs_ep_rr_sched_if.sv
// rtl/usb_fs_ep_rr_sched_if.sv - endpoint request / packet strobe / grant bundle for the round-robin scheduler
interface usb_fs_ep_rr_sched_if #(
   parameter int NUM_EPS = 4
);
   localparam int IW = (NUM_EPS > 1) ? $clog2(NUM_EPS) : 1;

   logic [NUM_EPS-1:0] ep_req;
   logic               pkt_start;
   logic               pkt_end;
   logic [NUM_EPS-1:0] ep_grant;
   logic               grant_valid;
   logic [IW-1:0]      grant_idx;
   logic               timeout;

   // endpoints and protocol engine side
   modport master (
      output ep_req, pkt_start, pkt_end,
      input  ep_grant, grant_valid, grant_idx, timeout
   );

   // scheduler side
   modport slave (
      input  ep_req, pkt_start, pkt_end,
      output ep_grant, grant_valid, grant_idx, timeout
   );
endinterface

// File: rtl/usb_fs_ep_rr_sched.sv
// rtl/usb_fs_ep_rr_sched.sv - packet-locked round-robin endpoint scheduler (optional GRANT watchdog: USB_SCHED_TIMEOUT_EN)
module usb_fs_ep_rr_sched #(
   parameter int NUM_EPS        = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   usb_fs_ep_rr_sched_if.slave   bus
);
   localparam int IW = (NUM_EPS > 1) ? $clog2(NUM_EPS) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

   state_t             state;
   logic [NUM_EPS-1:0] ep_grant_q;
   logic [IW-1:0]      grant_idx_q;
   logic [IW-1:0]      rr_ptr;

   logic               found;
   logic [IW-1:0]      winner;
   logic [IW-1:0]      next_ptr;
   logic               req_cur;
   logic               wd_hit;
   logic               release_now;

`ifdef USB_SCHED_TIMEOUT_EN
   localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   logic [WW-1:0] watchdog;
   logic          timeout_q;
   assign wd_hit      = (watchdog == WW'(TIMEOUT_CYCLES - 1));
   assign bus.timeout = timeout_q;
`else
   // watchdog limit has no effect in this build; the parameter stays for a common instantiation
   if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
   end
   assign wd_hit      = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   assign bus.ep_grant    = ep_grant_q;
   assign bus.grant_valid = |ep_grant_q;
   assign bus.grant_idx   = grant_idx_q;
   assign req_cur         = bus.ep_req[grant_idx_q];

   // first requester in search order starting at rr_ptr, wrapping modulo NUM_EPS
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int i = 0; i < NUM_EPS; i++) begin
         int c;
         c = int'(rr_ptr) + i;
         if (c >= NUM_EPS) c = c - NUM_EPS;
         if (!found && bus.ep_req[c]) begin
            found  = 1'b1;
            winner = IW'(c);
         end
      end
   end

   // packet completion, request withdrawal before pkt_start, or watchdog expiry ends the grant
   always_comb begin
      next_ptr = (int'(grant_idx_q) == NUM_EPS - 1) ? '0 : grant_idx_q + IW'(1);
      release_now = 1'b0;
      if (state == GRANT)
         release_now = (bus.pkt_start && bus.pkt_end) ||
                       (!bus.pkt_start && (!req_cur || wd_hit));
      else if (state == BUSY)
         release_now = bus.pkt_end;
   end

   // scheduler state machine with registered grant outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         ep_grant_q  <= '0;
         grant_idx_q <= '0;
         rr_ptr      <= '0;
`ifdef USB_SCHED_TIMEOUT_EN
         watchdog    <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
`ifdef USB_SCHED_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         if (release_now) begin
            state       <= IDLE;
            ep_grant_q  <= '0;
            grant_idx_q <= '0;
            rr_ptr      <= next_ptr;
`ifdef USB_SCHED_TIMEOUT_EN
            timeout_q   <= (state == GRANT) && !bus.pkt_start && req_cur && wd_hit;
`endif
         end else begin
            case (state)
               IDLE: begin
                  if (found) begin
                     state       <= GRANT;
                     ep_grant_q  <= NUM_EPS'(1) << winner;
                     grant_idx_q <= winner;
`ifdef USB_SCHED_TIMEOUT_EN
                     watchdog    <= '0;
`endif
                  end
               end
               GRANT: begin
                  if (bus.pkt_start) state <= BUSY;
`ifdef USB_SCHED_TIMEOUT_EN
                  watchdog <= watchdog + WW'(1);
`endif
               end
               BUSY:    state <= BUSY;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_usb_fs_ep_rr_sched.sv
// tb/tb_usb_fs_ep_rr_sched.sv - directed self-checking bench for the round-robin endpoint scheduler
module tb_usb_fs_ep_rr_sched;
   logic clk = 1'b0;
   logic reset_n;
   int   vecs = 0;
   int   errs = 0;

   usb_fs_ep_rr_sched_if #(.NUM_EPS(4)) bus ();

   usb_fs_ep_rr_sched #(.NUM_EPS(4), .TIMEOUT_CYCLES(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n       = 1'b0;
      bus.ep_req    = '0;
      bus.pkt_start = 1'b0;
      bus.pkt_end   = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      vecs++;
      if (bus.ep_grant !== 4'b0000 || bus.grant_valid !== 1'b0 ||
          bus.grant_idx !== 2'd0 || bus.timeout !== 1'b0) begin
         errs++;
         $display("FAIL reset: grant=%b valid=%b idx=%0d timeout=%b, want 0000/0/0/0",
                  bus.ep_grant, bus.grant_valid, bus.grant_idx, bus.timeout);
      end
   endtask

   task automatic test_basic();
      do_reset();
      bus.ep_req = 4'b0110;
      tick();
      vecs++;
      if (bus.ep_grant !== 4'b0010 || bus.grant_idx !== 2'd1 || bus.grant_valid !== 1'b1) begin
         errs++;
         $display("FAIL basic_grant: grant=%b idx=%0d valid=%b, want 0010/1/1",
                  bus.ep_grant, bus.grant_idx, bus.grant_valid);
      end
      bus.pkt_start = 1'b1;
      tick();
      bus.pkt_start = 1'b0;
      bus.pkt_end   = 1'b1;
      vecs++;
      if (bus.ep_grant !== 4'b0010) begin
         errs++;
         $display("FAIL basic_busy: grant=%b, want 0010", bus.ep_grant);
      end
      tick();
      bus.pkt_end = 1'b0;
      vecs++;
      if (bus.ep_grant !== 4'b0000 || bus.grant_idx !== 2'd0 || bus.grant_valid !== 1'b0) begin
         errs++;
         $display("FAIL basic_release: grant=%b idx=%0d valid=%b, want 0000/0/0",
                  bus.ep_grant, bus.grant_idx, bus.grant_valid);
      end
      tick();
      vecs++;
      if (bus.ep_grant !== 4'b0100 || bus.grant_idx !== 2'd2) begin
         errs++;
         $display("FAIL basic_next: grant=%b idx=%0d, want 0100/2", bus.ep_grant, bus.grant_idx);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g [5];
      exp_g[0] = 4'b0001;
      exp_g[1] = 4'b0010;
      exp_g[2] = 4'b0100;
      exp_g[3] = 4'b1000;
      exp_g[4] = 4'b0001;
      do_reset();
      bus.ep_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         vecs++;
         if (bus.ep_grant !== exp_g[k]) begin
            errs++;
            $display("FAIL rr_grant%0d: grant=%b, want %b", k, bus.ep_grant, exp_g[k]);
         end
         bus.pkt_start = 1'b1;
         bus.pkt_end   = 1'b1;
         tick();
         bus.pkt_start = 1'b0;
         bus.pkt_end   = 1'b0;
         vecs++;
         if (bus.ep_grant !== 4'b0000) begin
            errs++;
            $display("FAIL rr_idle%0d: grant=%b, want 0000", k, bus.ep_grant);
         end
      end
   endtask

   task automatic test_busy_lock();
      do_reset();
      bus.ep_req = 4'b0100;
      tick();
      bus.pkt_end = 1'b1;
      tick();
      bus.pkt_end = 1'b0;
      vecs++;
      if (bus.ep_grant !== 4'b0100) begin
         errs++;
         $display("FAIL grant_end_ignored: grant=%b, want 0100", bus.ep_grant);
      end
      bus.pkt_start = 1'b1;
      tick();
      bus.ep_req = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         tick();
         vecs++;
         if (bus.ep_grant !== 4'b0100 || bus.grant_idx !== 2'd2) begin
            errs++;
            $display("FAIL busy_hold%0d: grant=%b idx=%0d, want 0100/2", k, bus.ep_grant, bus.grant_idx);
         end
      end
      bus.pkt_start = 1'b0;
      bus.pkt_end   = 1'b1;
      tick();
      bus.pkt_end = 1'b0;
      vecs++;
      if (bus.ep_grant !== 4'b0000) begin
         errs++;
         $display("FAIL busy_release: grant=%b, want 0000", bus.ep_grant);
      end
   endtask

   task automatic test_req_drop();
      do_reset();
      bus.ep_req = 4'b0001;
      tick();
      vecs++;
      if (bus.ep_grant !== 4'b0001 || bus.grant_idx !== 2'd0) begin
         errs++;
         $display("FAIL drop_grant: grant=%b idx=%0d, want 0001/0", bus.ep_grant, bus.grant_idx);
      end
      bus.ep_req = 4'b0000;
      tick();
      vecs++;
      if (bus.ep_grant !== 4'b0000) begin
         errs++;
         $display("FAIL drop_release: grant=%b, want 0000", bus.ep_grant);
      end
      bus.ep_req = 4'b0011;
      tick();
      vecs++;
      if (bus.ep_grant !== 4'b0010 || bus.grant_idx !== 2'd1) begin
         errs++;
         $display("FAIL drop_ptr: grant=%b idx=%0d, want 0010/1", bus.ep_grant, bus.grant_idx);
      end
      bus.ep_req    = 4'b0000;
      bus.pkt_start = 1'b1;
      tick();
      bus.pkt_start = 1'b0;
      vecs++;
      if (bus.ep_grant !== 4'b0010) begin
         errs++;
         $display("FAIL start_beats_drop: grant=%b, want 0010", bus.ep_grant);
      end
      tick();
      vecs++;
      if (bus.ep_grant !== 4'b0010) begin
         errs++;
         $display("FAIL start_beats_drop_hold: grant=%b, want 0010", bus.ep_grant);
      end
      bus.pkt_end = 1'b1;
      tick();
      bus.pkt_end = 1'b0;
      vecs++;
      if (bus.ep_grant !== 4'b0000) begin
         errs++;
         $display("FAIL drop_busy_end: grant=%b, want 0000", bus.ep_grant);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.ep_req = 4'b0010;
      tick();
      bus.pkt_start = 1'b1;
      bus.pkt_end   = 1'b1;
      tick();
      bus.pkt_start = 1'b0;
      bus.pkt_end   = 1'b0;
      bus.ep_req    = 4'b0100;
      tick();
      bus.pkt_start = 1'b1;
      tick();
      bus.pkt_start = 1'b0;
      vecs++;
      if (bus.ep_grant !== 4'b0100) begin
         errs++;
         $display("FAIL mid_busy: grant=%b, want 0100", bus.ep_grant);
      end
      reset_n = 1'b0;
      tick();
      vecs++;
      if (bus.ep_grant !== 4'b0000 || bus.grant_valid !== 1'b0 ||
          bus.grant_idx !== 2'd0 || bus.timeout !== 1'b0) begin
         errs++;
         $display("FAIL mid_reset: grant=%b valid=%b idx=%0d timeout=%b, want 0000/0/0/0",
                  bus.ep_grant, bus.grant_valid, bus.grant_idx, bus.timeout);
      end
      reset_n    = 1'b1;
      bus.ep_req = 4'b1010;
      tick();
      vecs++;
      if (bus.ep_grant !== 4'b0010 || bus.grant_idx !== 2'd1) begin
         errs++;
         $display("FAIL mid_ptr_reset: grant=%b idx=%0d, want 0010/1", bus.ep_grant, bus.grant_idx);
      end
      do_reset();
      bus.ep_req = 4'b1000;
      tick();
      vecs++;
      if (bus.ep_grant !== 4'b1000 || bus.grant_idx !== 2'd3) begin
         errs++;
         $display("FAIL mid_ep3: grant=%b idx=%0d, want 1000/3", bus.ep_grant, bus.grant_idx);
      end
   endtask

   task automatic test_timeout();
      do_reset();
`ifdef USB_SCHED_TIMEOUT_EN
      bus.ep_req = 4'b0110;
      for (int k = 0; k < 8; k++) begin
         tick();
         vecs++;
         if (bus.ep_grant !== 4'b0010 || bus.timeout !== 1'b0) begin
            errs++;
            $display("FAIL wd_hold%0d: grant=%b timeout=%b, want 0010/0", k, bus.ep_grant, bus.timeout);
         end
      end
      tick();
      vecs++;
      if (bus.ep_grant !== 4'b0000 || bus.timeout !== 1'b1) begin
         errs++;
         $display("FAIL wd_fire: grant=%b timeout=%b, want 0000/1", bus.ep_grant, bus.timeout);
      end
      tick();
      vecs++;
      if (bus.ep_grant !== 4'b0100 || bus.timeout !== 1'b0) begin
         errs++;
         $display("FAIL wd_next: grant=%b timeout=%b, want 0100/0", bus.ep_grant, bus.timeout);
      end
`else
      bus.ep_req = 4'b0010;
      for (int k = 0; k < 100; k++) begin
         tick();
         vecs++;
         if (bus.ep_grant !== 4'b0010 || bus.timeout !== 1'b0) begin
            errs++;
            $display("FAIL nowd_hold%0d: grant=%b timeout=%b, want 0010/0", k, bus.ep_grant, bus.timeout);
         end
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_busy_lock();
      test_req_drop();
      test_reset_mid();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
